// File: rtl/reg_rename_file_pkg.sv
// Shared widths, status encodings and helpers for the rename register file.
// Build option: COMMIT_BYPASS_EN (consumed by rf_read_port).
package reg_rename_file_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 4;

  typedef logic [REG_ADDR_W-1:0] RegBus;
  typedef logic [TAG_W-1:0]      TagBus;
  typedef logic [DATA_W-1:0]     DataBus;

  localparam logic  VALID    = 1'b1;
  localparam logic  INVALID  = 1'b0;
  localparam logic  BUSY     = 1'b1;
  localparam logic  FREE     = 1'b0;
  localparam RegBus ZERO_REG = '0;

  // A commit retires the current mapping only if it comes from the newest renamer.
  function automatic logic tag_match(input logic busy, input TagBus cur_tag, input TagBus cmt_tag);
    return (busy == BUSY) && (cur_tag == cmt_tag);
  endfunction

endpackage

// File: rtl/reg_rename_file_rf_read_port.sv
// Combinational operand lookup: committed value or producing ROB tag.
// COMMIT_BYPASS_EN defined: forwards a same-cycle matching commit as a free value.
module rf_read_port
  import reg_rename_file_pkg::*;
(
  input  logic               en_i,
  input  RegBus              addr_i,
  input  logic [REG_NUM-1:0] busy_i,
  input  TagBus              tag_i  [REG_NUM],
  input  DataBus             data_i [REG_NUM],
  input  logic               commit_valid_i,
  input  RegBus              commit_reg_i,
  input  TagBus              commit_tag_i,
  input  DataBus             commit_data_i,
  output logic               busy_o,
  output TagBus              tag_o,
  output DataBus             data_o
);

`ifndef COMMIT_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_reg_i, commit_tag_i, commit_data_i};
`endif

  always_comb begin
    busy_o = FREE;
    tag_o  = '0;
    data_o = '0;
    if (en_i && (addr_i != ZERO_REG)) begin
      busy_o = busy_i[addr_i];
      tag_o  = tag_i[addr_i];
      data_o = data_i[addr_i];
`ifdef COMMIT_BYPASS_EN
      if (commit_valid_i && (commit_reg_i == addr_i) &&
          tag_match(busy_i[addr_i], tag_i[addr_i], commit_tag_i)) begin
        busy_o = FREE;
        data_o = commit_data_i;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy/ROB-tag rename status.
// Build option: COMMIT_BYPASS_EN (same-cycle commit forwarding on lookups).
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   clear,
  input  logic   commit_valid,
  input  RegBus  commit_reg,
  input  TagBus  commit_tag,
  input  DataBus commit_data,
  input  logic   rename_valid,
  input  RegBus  rename_reg,
  input  TagBus  rename_tag,
  input  logic   rs1_en,
  input  RegBus  rs1_addr,
  output logic   rs1_busy,
  output TagBus  rs1_tag,
  output DataBus rs1_data,
  input  logic   rs2_en,
  input  RegBus  rs2_addr,
  output logic   rs2_busy,
  output TagBus  rs2_tag,
  output DataBus rs2_data
);

  DataBus             data_q [REG_NUM];
  DataBus             data_d [REG_NUM];
  TagBus              tag_q  [REG_NUM];
  TagBus              tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Commit first, then clear/rename, so a same-cycle rename overrides the commit's busy release.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_valid && (commit_reg != ZERO_REG)) begin
      data_d[commit_reg] = commit_data;
      if (tag_match(busy_q[commit_reg], tag_q[commit_reg], commit_tag)) begin
        busy_d[commit_reg] = FREE;
      end
    end
    if (clear) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (rename_valid && (rename_reg != ZERO_REG)) begin
      busy_d[rename_reg] = BUSY;
      tag_d[rename_reg]  = rename_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      busy_q <= busy_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  rf_read_port u_rs1 (
    .en_i           (rs1_en),
    .addr_i         (rs1_addr),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
    .data_i         (data_q),
    .commit_valid_i (commit_valid),
    .commit_reg_i   (commit_reg),
    .commit_tag_i   (commit_tag),
    .commit_data_i  (commit_data),
    .busy_o         (rs1_busy),
    .tag_o          (rs1_tag),
    .data_o         (rs1_data)
  );

  rf_read_port u_rs2 (
    .en_i           (rs2_en),
    .addr_i         (rs2_addr),
    .busy_i         (busy_q),
    .tag_i          (tag_q),
    .data_i         (data_q),
    .commit_valid_i (commit_valid),
    .commit_reg_i   (commit_reg),
    .commit_tag_i   (commit_tag),
    .commit_data_i  (commit_data),
    .busy_o         (rs2_busy),
    .tag_o          (rs2_tag),
    .data_o         (rs2_data)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file; expected lookups queued per scenario and drained on both ports.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        commit_valid = 1'b0;
  logic [4:0]  commit_reg = '0;
  logic [3:0]  commit_tag = '0;
  logic [31:0] commit_data = '0;
  logic        rename_valid = 1'b0;
  logic [4:0]  rename_reg = '0;
  logic [3:0]  rename_tag = '0;
  logic        rs1_en = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic        rs1_busy;
  logic [3:0]  rs1_tag;
  logic [31:0] rs1_data;
  logic        rs2_en = 1'b0;
  logic [4:0]  rs2_addr = '0;
  logic        rs2_busy;
  logic [3:0]  rs2_tag;
  logic [31:0] rs2_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  addr;
    logic        busy;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clear        (clear),
    .commit_valid (commit_valid),
    .commit_reg   (commit_reg),
    .commit_tag   (commit_tag),
    .commit_data  (commit_data),
    .rename_valid (rename_valid),
    .rename_reg   (rename_reg),
    .rename_tag   (rename_tag),
    .rs1_en       (rs1_en),
    .rs1_addr     (rs1_addr),
    .rs1_busy     (rs1_busy),
    .rs1_tag      (rs1_tag),
    .rs1_data     (rs1_data),
    .rs2_en       (rs2_en),
    .rs2_addr     (rs2_addr),
    .rs2_busy     (rs2_busy),
    .rs2_tag      (rs2_tag),
    .rs2_data     (rs2_data)
  );

  function automatic exp_t mk(string name, logic en, logic [4:0] addr, logic busy,
                              logic [3:0] tag, logic [31:0] data);
    exp_t x;
    x.name = name; x.en = en; x.addr = addr; x.busy = busy; x.tag = tag; x.data = data;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; commit_valid = 1'b0; rename_valid = 1'b0;
  endtask

  task automatic do_rename(input logic [4:0] r, input logic [3:0] t);
    rename_valid = 1'b1; rename_reg = r; rename_tag = t;
  endtask

  task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
    commit_valid = 1'b1; commit_reg = r; commit_tag = t; commit_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sb.push_back(mk("reset_x5", 1'b1, 5'd5, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("reset_x31", 1'b1, 5'd31, 1'b0, 4'd0, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_rename_commit();
    do_rename(5'd3, 4'd4);
    tick(); idle();
    sb.push_back(mk("renamed_x3", 1'b1, 5'd3, 1'b1, 4'd4, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    do_commit(5'd3, 4'd4, 32'hDEADBEEF);
    tick(); idle();
    sb.push_back(mk("committed_x3", 1'b1, 5'd3, 1'b0, 4'd0, 32'hDEADBEEF));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_younger_rename();
    do_rename(5'd3, 4'd4);
    tick();
    do_rename(5'd3, 4'd7);
    tick(); idle();
    do_commit(5'd3, 4'd4, 32'h11);
    tick(); idle();
    sb.push_back(mk("stale_commit_keeps_busy", 1'b1, 5'd3, 1'b1, 4'd7, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    clear = 1'b1;
    tick(); idle();
    sb.push_back(mk("stale_commit_data_stored", 1'b1, 5'd3, 1'b0, 4'd0, 32'h11));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_same_cycle();
    // A rename of the looked-up register is not visible until the next cycle.
    do_rename(5'd3, 4'd7);
    sb.push_back(mk("same_cycle_rename_hidden", 1'b1, 5'd3, 1'b0, 4'd0, 32'h11));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    tick();
    do_commit(5'd3, 4'd7, 32'h22);
    do_rename(5'd3, 4'd9);
    tick(); idle();
    sb.push_back(mk("rename_beats_commit", 1'b1, 5'd3, 1'b1, 4'd9, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    do_commit(5'd3, 4'd9, 32'h99);
    tick(); idle();
    sb.push_back(mk("tag9_commit_overwrites", 1'b1, 5'd3, 1'b0, 4'd0, 32'h99));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_x0_rdy();
    do_rename(5'd0, 4'd2);
    do_commit(5'd0, 4'd0, 32'h5);
    tick(); idle();
    sb.push_back(mk("x0_stays_zero", 1'b1, 5'd0, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("disabled_lookup", 1'b0, 5'd3, 1'b0, 4'd0, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    rdy = 1'b0;
    do_rename(5'd6, 4'd5);
    do_commit(5'd3, 4'd0, 32'h77);
    tick(); idle();
    rdy = 1'b1;
    sb.push_back(mk("rdy_low_no_rename", 1'b1, 5'd6, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("rdy_low_no_commit", 1'b1, 5'd3, 1'b0, 4'd0, 32'h99));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_clear_bypass();
    do_rename(5'd1, 4'd1);
    tick();
    do_rename(5'd2, 4'd2);
    tick(); idle();
    sb.push_back(mk("x1_busy_before_clear", 1'b1, 5'd1, 1'b1, 4'd1, 32'h0));
    sb.push_back(mk("x2_busy_before_clear", 1'b1, 5'd2, 1'b1, 4'd2, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    tick();
    clear = 1'b1;
    do_commit(5'd1, 4'd1, 32'h33);
    do_rename(5'd4, 4'd6);
`ifdef COMMIT_BYPASS_EN
    sb.push_back(mk("bypass_same_cycle", 1'b1, 5'd1, 1'b0, 4'd0, 32'h33));
`else
    sb.push_back(mk("no_bypass_same_cycle", 1'b1, 5'd1, 1'b1, 4'd1, 32'h0));
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    tick(); idle();
    sb.push_back(mk("clear_x1_committed", 1'b1, 5'd1, 1'b0, 4'd0, 32'h33));
    sb.push_back(mk("clear_x2_free", 1'b1, 5'd2, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("clear_drops_rename", 1'b1, 5'd4, 1'b0, 4'd0, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_rename(5'd7, 4'd8);
    tick();
    do_rename(5'd7, 4'd9);
    do_commit(5'd4, 4'd0, 32'hA5);
    tick(); idle();
    sb.push_back(mk("b2b_x7_latest_tag", 1'b1, 5'd7, 1'b1, 4'd9, 32'h0));
    sb.push_back(mk("b2b_x4_data", 1'b1, 5'd4, 1'b0, 4'd0, 32'hA5));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
    do_rename(5'd5, 4'd3);
    rst = 1'b1;
    tick(); idle();
    rst = 1'b0;
    sb.push_back(mk("midreset_x7", 1'b1, 5'd7, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("midreset_x4", 1'b1, 5'd4, 1'b0, 4'd0, 32'h0));
    sb.push_back(mk("midreset_x5", 1'b1, 5'd5, 1'b0, 4'd0, 32'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rs1_en = e.en; rs2_en = e.en; rs1_addr = e.addr; rs2_addr = e.addr;
      #1;
      n_checks++;
      if (rs1_busy !== e.busy || (e.busy && rs1_tag !== e.tag) || (!e.busy && rs1_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs1: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs1_busy, rs1_tag, rs1_data, e.busy, e.tag, e.data);
      end
      n_checks++;
      if (rs2_busy !== e.busy || (e.busy && rs2_tag !== e.tag) || (!e.busy && rs2_data !== e.data)) begin
        n_fail++;
        $display("FAIL %s rs2: got busy=%b tag=%0d data=%h, want busy=%b tag=%0d data=%h", e.name, rs2_busy, rs2_tag, rs2_data, e.busy, e.tag, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_x0_rdy();
    test_clear_bypass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
